// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Control unit for a single-cycle ARM-subset processor. Decodes the
//   instruction fields into datapath controls. Holds the NZCV condition
//   flags. Gates the state-changing controls (PC load, register write,
//   memory write, flag write) with the condition check.
//
// Ports
//   clk        in   clock; the flag register updates on the rising edge
//   rst        in   asynchronous active-high reset, clears the flags
//   cond[3:0]  in   condition code, instruction bits [31:28]
//   alu_flags  in   {N,Z,C,V} produced by the ALU this cycle
//   op[1:0]    in   00 data-processing, 01 memory, 10 branch, 11 undefined
//   funct[5:0] in   {I, cmd[3:0], S}
//   rd[3:0]    in   destination register field
//   sh[1:0]    in   shift type: LSL, LSR, ASR, ROR
//   pc_src     out  PC loads the result (branch, or write to R15)
//   reg_write  out  register file write enable
//   mem_write  out  data memory write enable
//   mem_reg    out  writeback source: 1 memory data, 0 ALU result
//   alu_src    out  ALU operand B: 1 extended immediate, 0 register
//   imm_src    out  extender mode: 00 imm8, 01 imm12, 10 imm24
//   reg_src    out  [0] Rn address = R15, [1] Rm address = Rd
//   alu_ctrl   out  ALU operation select
// ---------------------------------------------------------------------------
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [1:0] sh,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_reg,
    output logic       alu_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [3:0] alu_ctrl
);

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_RSB = 4'b0101;
    localparam logic [3:0] ALU_ADC = 4'b0110;
    localparam logic [3:0] ALU_SBC = 4'b0111;
    localparam logic [3:0] ALU_MOV = 4'b1000;
    localparam logic [3:0] ALU_MVN = 4'b1001;
    localparam logic [3:0] ALU_BIC = 4'b1010;
    localparam logic [3:0] ALU_LSL = 4'b1011;
    localparam logic [3:0] ALU_LSR = 4'b1100;
    localparam logic [3:0] ALU_ASR = 4'b1101;
    localparam logic [3:0] ALU_ROR = 4'b1110;

    logic [3:0] flags_r;          // {N,Z,C,V}
    logic       branch_s;
    logic       raw_reg_write_s;
    logic       raw_mem_write_s;
    logic [1:0] flag_write_s;     // [1] NZ, [1] loaded from alu_flags[3:2]; [0] CV
    logic       cond_ex_s;

    logic       i_bit_s;
    logic [3:0] cmd_s;
    logic       s_bit_s;

    assign i_bit_s = funct[5];
    assign cmd_s   = funct[4:1];
    assign s_bit_s = funct[0];

    // Evaluate an ARM condition code against an {N,Z,C,V} flag set.
    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'b0000: cond_check = z;
            4'b0001: cond_check = ~z;
            4'b0010: cond_check = cf;
            4'b0011: cond_check = ~cf;
            4'b0100: cond_check = n;
            4'b0101: cond_check = ~n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = ~v;
            4'b1000: cond_check = cf & ~z;
            4'b1001: cond_check = ~cf | z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = ~z & (n == v);
            4'b1101: cond_check = z | (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    // Flag register: cleared by reset, otherwise loads NZ / CV halves when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'b0000;
        end else begin
            if (cond_ex_s && flag_write_s[1]) begin
                flags_r[3:2] <= alu_flags[3:2];
            end
            if (cond_ex_s && flag_write_s[0]) begin
                flags_r[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Condition check against the stored flags.
    always_comb begin
        cond_ex_s = cond_check(cond, flags_r);
    end

    // Main decoder: ungated controls plus the raw enables that the condition gates.
    always_comb begin
        branch_s        = 1'b0;
        raw_reg_write_s = 1'b0;
        raw_mem_write_s = 1'b0;
        flag_write_s    = 2'b00;
        mem_reg         = 1'b0;
        alu_src         = 1'b0;
        imm_src         = 2'b00;
        reg_src         = 2'b00;
        alu_ctrl        = ALU_ADD;
        case (op)
            2'b00: begin
                alu_src         = i_bit_s;
                raw_reg_write_s = 1'b1;
                case (cmd_s)
                    4'b0000: alu_ctrl = ALU_AND;
                    4'b0001: alu_ctrl = ALU_EOR;
                    4'b0010: alu_ctrl = ALU_SUB;
                    4'b0011: alu_ctrl = ALU_RSB;
                    4'b0100: alu_ctrl = ALU_ADD;
                    4'b0101: alu_ctrl = ALU_ADC;
                    4'b0110: alu_ctrl = ALU_SBC;
                    4'b1000: alu_ctrl = ALU_AND;
                    4'b1001: alu_ctrl = ALU_EOR;
                    4'b1010: alu_ctrl = ALU_SUB;
                    4'b1011: alu_ctrl = ALU_ADD;
                    4'b1100: alu_ctrl = ALU_ORR;
                    4'b1101: begin
                        // Register MOV with a non-LSL shift type becomes a pure shift.
                        if (!i_bit_s && (sh != 2'b00)) begin
                            case (sh)
                                2'b01:   alu_ctrl = ALU_LSR;
                                2'b10:   alu_ctrl = ALU_ASR;
                                2'b11:   alu_ctrl = ALU_ROR;
                                default: alu_ctrl = ALU_LSL;
                            endcase
                        end else begin
                            alu_ctrl = ALU_MOV;
                        end
                    end
                    4'b1110: alu_ctrl = ALU_BIC;
                    4'b1111: alu_ctrl = ALU_MVN;
                    default: alu_ctrl = ALU_ADD;   // cmd 0111, unsupported
                endcase
                // Compares/tests and the unsupported cmd never write a register.
                case (cmd_s)
                    4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011: raw_reg_write_s = 1'b0;
                    default:                                     raw_reg_write_s = 1'b1;
                endcase
                // Only arithmetic ops produce meaningful C and V.
                case (cmd_s)
                    4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1010, 4'b1011:
                        flag_write_s = {s_bit_s, s_bit_s};
                    default:
                        flag_write_s = {s_bit_s, 1'b0};
                endcase
            end
            2'b01: begin
                alu_src  = 1'b1;
                imm_src  = 2'b01;
                alu_ctrl = funct[3] ? ALU_ADD : ALU_SUB;
                if (funct[0]) begin
                    raw_reg_write_s = 1'b1;
                    mem_reg         = 1'b1;
                    reg_src         = 2'b00;
                end else begin
                    raw_mem_write_s = 1'b1;
                    reg_src         = 2'b10;
                end
            end
            2'b10: begin
                branch_s = 1'b1;
                alu_src  = 1'b1;
                imm_src  = 2'b10;
                reg_src  = 2'b01;
                alu_ctrl = ALU_ADD;
            end
            default: begin
                alu_ctrl = ALU_ADD;
            end
        endcase
    end

    // Gate the state-changing controls with the condition result.
    always_comb begin
        pc_src    = cond_ex_s & (branch_s | (raw_reg_write_s & (rd == 4'b1111)));
        reg_write = cond_ex_s & raw_reg_write_s;
        mem_write = cond_ex_s & raw_mem_write_s;
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//   Directed-vector bench for control_unit. Each vector compares the full
//   control word {pc_src, reg_write, mem_write, mem_reg, alu_src, imm_src,
//   reg_src, alu_ctrl} against a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [1:0] sh;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_reg;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [3:0] alu_ctrl;

    logic [12:0] ctl;
    assign ctl = {pc_src, reg_write, mem_write, mem_reg, alu_src,
                  imm_src, reg_src, alu_ctrl};

    int tests_run;
    int tests_failed;

    control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .cond      (cond),
        .alu_flags (alu_flags),
        .op        (op),
        .funct     (funct),
        .rd        (rd),
        .sh        (sh),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .mem_reg   (mem_reg),
        .alu_src   (alu_src),
        .imm_src   (imm_src),
        .reg_src   (reg_src),
        .alu_ctrl  (alu_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed control word against its expected value.
    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply one instruction and let it settle away from the clock edge.
    task automatic drive(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r, input logic [1:0] s);
        cond  = c;
        op    = o;
        funct = f;
        rd    = r;
        sh    = s;
        #1;
    endtask

    // Let one rising edge pass, return just after the next falling edge.
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Probe the stored flags: a plain ADD R3 under condition c writes iff c holds.
    task automatic probe(input string tag, input logic [3:0] c, input logic exp_write);
        drive(c, 2'b00, 6'b001000, 4'd3, 2'b00);
        check(tag, ctl, {1'b0, exp_write, 11'b000_0000_0000});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        alu_flags = 4'b0000;
        cond = 4'b0000; op = 2'b00; funct = 6'b000000; rd = 4'd0; sh = 2'b00;

        // Reset: flags clear, EQ fails, AND decode still visible
        @(negedge clk);
        drive(4'b0000, 2'b00, 6'b000000, 4'd0, 2'b00);
        check("reset_and_eq", ctl, 13'b0_0_0_0_0_00_00_0010);
        rst = 1'b0;

        // ADD register, always
        drive(4'b1110, 2'b00, 6'b001000, 4'd3, 2'b00);
        check("add_reg", ctl, 13'b0_1_0_0_0_00_00_0000);

        // CMP sets Z
        alu_flags = 4'b0100;
        drive(4'b1110, 2'b00, 6'b010101, 4'd0, 2'b00);
        check("cmp_decode", ctl, 13'b0_0_0_0_0_00_00_0001);
        step;
        probe("eq_after_cmp", 4'b0000, 1'b1);
        probe("ne_after_cmp", 4'b0001, 1'b0);

        // ANDS: only N,Z update (N=1,Z=0), C,V hold at 0
        alu_flags = 4'b1011;
        drive(4'b1110, 2'b00, 6'b000001, 4'd3, 2'b00);
        check("ands_decode", ctl, 13'b0_1_0_0_0_00_00_0010);
        step;
        probe("mi_after_ands", 4'b0100, 1'b1);
        probe("cs_after_ands", 4'b0010, 1'b0);
        probe("eq_after_ands", 4'b0000, 1'b0);

        // ADDS: all flags -> N=0 Z=0 C=1 V=1
        alu_flags = 4'b0011;
        drive(4'b1110, 2'b00, 6'b001001, 4'd3, 2'b00);
        step;
        probe("hi", 4'b1000, 1'b1);
        probe("ge", 4'b1010, 1'b0);
        probe("lt", 4'b1011, 1'b1);
        probe("gt", 4'b1100, 1'b0);
        probe("le", 4'b1101, 1'b1);
        probe("vs", 4'b0110, 1'b1);
        probe("vc", 4'b0111, 1'b0);
        probe("cc", 4'b0011, 1'b0);
        probe("ls", 4'b1001, 1'b0);
        probe("pl", 4'b0101, 1'b1);

        // CMP under failing EQ must not touch the flags
        alu_flags = 4'b0100;
        drive(4'b0000, 2'b00, 6'b010101, 4'd0, 2'b00);
        step;
        probe("ne_gated_cmp", 4'b0001, 1'b1);
        probe("cs_gated_cmp", 4'b0010, 1'b1);

        // Asynchronous reset between clock edges clears C
        #1;
        rst = 1'b1;
        #1;
        probe("cs_async_rst", 4'b0010, 1'b0);
        rst = 1'b0;
        step;

        // Reset held over an edge beats an ADDS flag write
        alu_flags = 4'b1111;
        rst = 1'b1;
        drive(4'b1110, 2'b00, 6'b001001, 4'd3, 2'b00);
        step;
        rst = 1'b0;
        probe("rst_wins_cs", 4'b0010, 1'b0);
        probe("rst_wins_pl", 4'b0101, 1'b1);

        // Memory
        drive(4'b1110, 2'b01, 6'b011001, 4'd2, 2'b00);
        check("ldr_up", ctl, 13'b0_1_0_1_1_01_00_0000);
        drive(4'b1110, 2'b01, 6'b011001, 4'd15, 2'b00);
        check("ldr_pc", ctl, 13'b1_1_0_1_1_01_00_0000);
        drive(4'b1110, 2'b01, 6'b010000, 4'd2, 2'b00);
        check("str_down", ctl, 13'b0_0_1_0_1_01_10_0001);
        drive(4'b1111, 2'b01, 6'b010000, 4'd2, 2'b00);
        check("str_never", ctl, 13'b0_0_0_0_1_01_10_0001);

        // Branch
        drive(4'b1110, 2'b10, 6'b000000, 4'd0, 2'b00);
        check("b_al", ctl, 13'b1_0_0_0_1_10_01_0000);
        drive(4'b1111, 2'b10, 6'b000000, 4'd0, 2'b00);
        check("b_never", ctl, 13'b0_0_0_0_1_10_01_0000);

        // Writes to R15 and R15-targeted compare
        drive(4'b1110, 2'b00, 6'b001000, 4'd15, 2'b00);
        check("add_pc", ctl, 13'b1_1_0_0_0_00_00_0000);
        drive(4'b1110, 2'b00, 6'b010001, 4'd15, 2'b00);
        check("tst_pc", ctl, 13'b0_0_0_0_0_00_00_0010);

        // MOV variants and other commands
        drive(4'b1110, 2'b00, 6'b011010, 4'd1, 2'b10);
        check("mov_asr", ctl, 13'b0_1_0_0_0_00_00_1101);
        drive(4'b1110, 2'b00, 6'b011010, 4'd1, 2'b11);
        check("mov_ror", ctl, 13'b0_1_0_0_0_00_00_1110);
        drive(4'b1110, 2'b00, 6'b011010, 4'd1, 2'b00);
        check("mov_lsl0", ctl, 13'b0_1_0_0_0_00_00_1000);
        drive(4'b1110, 2'b00, 6'b111010, 4'd1, 2'b10);
        check("mov_imm", ctl, 13'b0_1_0_0_1_00_00_1000);
        drive(4'b1110, 2'b00, 6'b011110, 4'd1, 2'b00);
        check("mvn", ctl, 13'b0_1_0_0_0_00_00_1001);
        drive(4'b1110, 2'b00, 6'b011100, 4'd1, 2'b00);
        check("bic", ctl, 13'b0_1_0_0_0_00_00_1010);
        drive(4'b1110, 2'b00, 6'b011000, 4'd1, 2'b00);
        check("orr", ctl, 13'b0_1_0_0_0_00_00_0011);
        drive(4'b1110, 2'b00, 6'b001110, 4'd1, 2'b00);
        check("cmd_0111", ctl, 13'b0_0_0_0_0_00_00_0000);
        drive(4'b1110, 2'b11, 6'b111111, 4'd15, 2'b11);
        check("op_11", ctl, 13'b0_0_0_0_0_00_00_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
